// File: rtl/vga_fb_arbiter_pkg.sv
// vga_fb_arbiter_pkg: VGA 640x480 timing constants, framebuffer geometry and
// the scan-out FSM state type shared by the framebuffer arbiter slice.
// Timing values match those used by vga_sync, so flush points line up.
package vga_fb_arbiter_pkg;

  // Horizontal timing in pixel clocks
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800

  // Vertical timing in lines
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

  // Framebuffer geometry at 4 pixels per RAM word
  localparam int PIXELS_PER_WORD = 4;
  localparam int WORDS_PER_LINE  = H_VISIBLE / PIXELS_PER_WORD;     // 160
  localparam int FB_WORDS        = WORDS_PER_LINE * V_VISIBLE;      // 76800

  // First line of vertical blanking: the prefetch pipeline restarts here
  localparam int FLUSH_Y = V_VISIBLE;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,  // after reset: writer owns the RAM, no scan-out
    ST_RUN        = 2'd1,  // prefetching the frame
    ST_DONE       = 2'd2   // whole frame fetched, FIFO draining
  } fb_state_t;

endpackage

// File: rtl/vga_fb_fifo.sv
// vga_fb_fifo: synchronous show-ahead FIFO holding prefetched framebuffer words.
// Latency: push visible at head/count the next cycle; head is the oldest word, no read delay.
// Backpressure: pop on empty is ignored; push on full is dropped unless a pop frees a slot.
// Ports: clk, rst (sync, active-high), clear (sync flush), push/push_data,
//        pop, count (occupancy), head (oldest word), empty, full.
module vga_fb_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port framebuffer RAM between display prefetch and a pixel writer.
// Latency: pix_valid/pix_data lag display/pixel_x by 1 cycle; write grant is combinational (wr_ack same cycle).
// Backpressure: writer holds wr_req/addr/data until wr_ack; fetch wins when FIFO level < LOW_MARK.
// Ports: clk, rst; display/pixel_x/pixel_y from vga_sync; wr_req/wr_addr/wr_data/wr_ack
//        writer port; mem_en/mem_we/mem_addr/mem_wdata/mem_rdata RAM port;
//        pix_valid/pix_data colour stream; underrun sticky starvation flag.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int PIX_W        = 4,
  parameter int PIX_PER_WORD = 4,
  parameter int ADDR_W       = 17,
  parameter int FIFO_DEPTH   = 16,
  parameter int LOW_MARK     = 8,
  localparam int DATA_W      = PIX_W * PIX_PER_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              display,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  output logic              underrun
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int LVL_W = CNT_W + 1;
  localparam int SEL_W = $clog2(PIX_PER_WORD);

  fb_state_t         state;
  fb_state_t         state_nxt;
  logic [ADDR_W-1:0] fetch_addr;
  logic              inflight;     // a read was issued last cycle; its data is on mem_rdata now
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic [LVL_W-1:0]  level;
  logic              flush;
  logic              grant_fetch;
  logic              grant_wr;
  logic              scan_active;
  logic              pop_req;
  logic [SEL_W-1:0]  pix_sel_idx;
  logic [PIX_W-1:0]  pix_sel;

  // First pixel of vertical blanking: restart the prefetch for the next frame.
  assign flush = (pixel_y == 10'(FLUSH_Y)) && (pixel_x == '0);

  // Words already buffered plus the one still coming back from the RAM.
  assign level = {1'b0, fifo_count} + LVL_W'(inflight);

  // Arbitration and next state. Urgent fetches beat the writer; otherwise the
  // writer gets the slot and any spare slot tops the FIFO up.
  always_comb begin
    state_nxt   = state;
    grant_fetch = 1'b0;
    grant_wr    = 1'b0;
    if (rst) begin
      state_nxt = ST_WAIT_FRAME;
    end else if (flush) begin
      // The FIFO is being cleared this cycle, so a fetch would be wasted.
      grant_wr  = wr_req;
      state_nxt = ST_RUN;
    end else if (state == ST_RUN) begin
      if (level < LVL_W'(LOW_MARK)) begin
        grant_fetch = 1'b1;
      end else if (wr_req) begin
        grant_wr = 1'b1;
      end else if (!fifo_full && (level < LVL_W'(FIFO_DEPTH))) begin
        grant_fetch = 1'b1;
      end
      if (grant_fetch && (fetch_addr == ADDR_W'(FB_WORDS - 1))) begin
        state_nxt = ST_DONE;
      end
    end else begin
      grant_wr = wr_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_WAIT_FRAME;
      fetch_addr <= '0;
      inflight   <= 1'b0;
    end else begin
      state    <= state_nxt;
      // grant_fetch is never set at the flush point, so this also drops a
      // read that was in flight across it.
      inflight <= grant_fetch;
      if (flush) begin
        fetch_addr <= '0;
      end else if (grant_fetch) begin
        fetch_addr <= fetch_addr + 1'b1;
      end
    end
  end

  // RAM port: combinational grant so a write can complete in the request cycle.
  assign mem_en    = grant_fetch || grant_wr;
  assign mem_we    = grant_wr;
  assign mem_addr  = grant_wr ? wr_addr : (grant_fetch ? fetch_addr : '0);
  assign mem_wdata = grant_wr ? wr_data : '0;
  assign wr_ack    = grant_wr;

  // Scan-out only consumes words once a frame has been started.
  assign scan_active = display && (state != ST_WAIT_FRAME);
  assign pix_sel_idx = pixel_x[SEL_W-1:0];
  assign pop_req     = scan_active && (pix_sel_idx == {SEL_W{1'b1}});
  assign pix_sel     = fifo_head[pix_sel_idx*PIX_W +: PIX_W];

  vga_fb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (inflight && !flush),
    .push_data (mem_rdata),
    .pop       (pop_req),
    .count     (fifo_count),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      underrun  <= 1'b0;
    end else begin
      pix_valid <= display;
      pix_data  <= (scan_active && !fifo_empty) ? pix_sel : '0;
      // Sticky: any starved visible pixel marks the frame as corrupted.
      if (scan_active && fifo_empty) underrun <= 1'b1;
    end
  end

endmodule
